// File: rtl/guess_input_cond.sv
// Input conditioning for the guessing game: synchronizes and debounces four
// buttons, generates the periodic step enable, and latches presses into a guess.
// Latency: btn_db follows a steady btn after DB_CYCLES+2 edges; b picks up a press
// one edge after the debounced rising edge. No backpressure: the FSM samples en/b.
//
// Ports:
//   clk    - system clock (only clock)
//   rst    - synchronous active-high reset
//   btn    - raw asynchronous push-buttons, active-high
//   en     - one-cycle game-step enable, once every TICK_CYCLES cycles
//   b      - guess accumulated over the step window, valid while en is high
//   btn_db - debounced button levels
module guess_input_cond #(
    parameter int DB_CYCLES   = 1_000_000,
    parameter int TICK_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    output logic       en,
    output logic [3:0] b,
    output logic [3:0] btn_db
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam int TW = $clog2(TICK_CYCLES);

    localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);

    logic [3:0]    s1;
    logic [3:0]    s2;
    logic [3:0]    db_d;
    logic [CW-1:0] db_cnt [4];
    logic [TW-1:0] tick_cnt;
    logic [3:0]    press;

    // Two-stage synchronizer, per-bit debounce and edge-detect delay.
    // A bit's counter only runs while the synchronized level disagrees with the
    // accepted level, so any agreeing cycle (a bounce back) restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 4'b0000;
            s2     <= 4'b0000;
            btn_db <= 4'b0000;
            db_d   <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            s1   <= btn;
            s2   <= s1;
            db_d <= btn_db;
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == btn_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    btn_db[i] <= s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Free-running step counter; en is a pure decode of the registered count,
    // so it is glitch-free and exactly one cycle wide.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_ONE;
        end
    end

    assign en    = (tick_cnt == TICK_LAST);
    assign press = btn_db & ~db_d;

    // Guess latch: presses accumulate during the window. On the en cycle the
    // window closes and restarts with any press pulse seen in that same cycle,
    // so a press coincident with en lands in the next guess rather than vanishing.
    always_ff @(posedge clk) begin
        if (rst) begin
            b <= 4'b0000;
        end else if (en) begin
            b <= press;
        end else begin
            b <= b | press;
        end
    end

endmodule

// File: tb/tb_guess_input_cond.sv
// Bench for guess_input_cond with DB_CYCLES=4, TICK_CYCLES=16: directed
// scenarios followed by randomized button/reset traffic, every cycle compared
// against a behavioural model built from sample histories and window rules.
module tb_guess_input_cond;

    localparam int DB   = 4;
    localparam int TICK = 16;

    logic       clk;
    logic       rst;
    logic [3:0] btn;
    logic       en;
    logic [3:0] b;
    logic [3:0] btn_db;

    guess_input_cond #(
        .DB_CYCLES   (DB),
        .TICK_CYCLES (TICK)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn    (btn),
        .en     (en),
        .b      (b),
        .btn_db (btn_db)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Reference model state.
    logic [3:0] hist [$];   // raw btn values sampled by the last two edges
    logic [3:0] s2h  [$];   // synchronized samples used by the last DB edges
    logic [3:0] m_db;       // accepted (debounced) levels
    logic [3:0] m_dbp;      // accepted levels one cycle earlier
    logic [3:0] m_b;        // guess register
    int         since;      // edges since the last reset edge
    logic [3:0] cur_btn;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance the model over one rising edge, given the inputs present at it.
    task automatic model_edge(input logic r, input logic [3:0] bv);
        logic [3:0] s2_now;
        logic [3:0] press_now;
        logic [3:0] db_next;
        logic       en_now;
        bit         all_diff;
        if (r) begin
            hist = '{4'h0, 4'h0};
            s2h.delete();
            m_db  = 4'h0;
            m_dbp = 4'h0;
            m_b   = 4'h0;
            since = 0;
        end else begin
            en_now = ((since % TICK) == TICK - 1);
            // Synchronized level at this edge is the btn sampled two edges ago.
            s2_now = hist[0];
            void'(hist.pop_front());
            hist.push_back(bv);
            s2h.push_back(s2_now);
            if (s2h.size() > DB) void'(s2h.pop_front());
            // A level is accepted once the last DB synchronized samples all
            // disagree with the currently accepted level.
            db_next = m_db;
            for (int i = 0; i < 4; i++) begin
                if (s2h.size() == DB) begin
                    all_diff = 1'b1;
                    foreach (s2h[k]) if (s2h[k][i] == m_db[i]) all_diff = 1'b0;
                    if (all_diff) db_next[i] = ~m_db[i];
                end
            end
            press_now = m_db & ~m_dbp;
            m_b   = en_now ? press_now : (m_b | press_now);
            m_dbp = m_db;
            m_db  = db_next;
            since++;
        end
    endtask

    task automatic step(input logic r, input logic [3:0] bv);
        @(negedge clk);
        rst     = r;
        btn     = bv;
        cur_btn = bv;
        @(posedge clk);
        model_edge(r, bv);
        cyc++;
        #1;
        chk("en", {3'b000, en}, {3'b000, ((since % TICK) == TICK - 1)});
        chk("b", b, m_b);
        chk("btn_db", btn_db, m_db);
    endtask

    task automatic hold(input logic [3:0] bv, input int n);
        for (int j = 0; j < n; j++) step(1'b0, bv);
    endtask

    // Idle (keeping the current buttons) until the current cycle has phase p.
    task automatic wait_phase(input int p);
        for (int j = 0; j < TICK + 1; j++) begin
            if ((since % TICK) == p) break;
            step(1'b0, cur_btn);
        end
    endtask

    initial begin
        rst     = 1'b1;
        btn     = 4'h0;
        cur_btn = 4'h0;
        since   = 0;
        m_db    = 4'h0;
        m_dbp   = 4'h0;
        m_b     = 4'h0;

        // Reset for two cycles, then run past several en pulses.
        step(1'b1, 4'h0);
        step(1'b1, 4'h0);
        hold(4'h0, 40);

        // Bounce on btn[0], then a steady press.
        for (int k = 0; k < 20; k++) step(1'b0, {3'b000, 1'((k / 2) % 2)});
        hold(4'h1, 40);
        hold(4'h0, 20);

        // Held btn[2] across two windows, then release.
        wait_phase(0);
        hold(4'h4, 40);
        hold(4'h0, 20);

        // Two buttons pressed one after the other in one window.
        wait_phase(0);
        hold(4'h2, 5);
        hold(4'h8, 5);
        hold(4'h0, 30);

        // Press pulse landing on the en cycle, then one cycle earlier.
        wait_phase(9);
        hold(4'h1, 10);
        hold(4'h0, 30);
        wait_phase(8);
        hold(4'h1, 10);
        hold(4'h0, 30);

        // Latch btn[3], reset mid-window, then a button held through reset.
        wait_phase(0);
        hold(4'h8, 8);
        hold(4'h0, 4);
        step(1'b1, 4'h0);
        hold(4'h0, 20);
        hold(4'h4, 6);
        step(1'b1, 4'h4);
        hold(4'h4, 20);
        hold(4'h0, 20);

        // Randomized traffic: mixed hold lengths (bounces and clean presses)
        // with occasional resets.
        for (int k = 0; k < 200; k++) begin
            logic [3:0] bv;
            int         len;
            bv  = 4'($urandom);
            len = $urandom_range(1, 14);
            for (int j = 0; j < len; j++) step(($urandom_range(0, 199) == 0), bv);
        end
        hold(4'h0, 20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
